// File: rtl/i2s_frame_unpacker.sv
// Reads one I2S frame back from the receiver's bit-wide circular RAM
// and streams each 32-bit slot's top bits as a channel sample.
module i2s_frame_unpacker #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int SAMPLE_BITS   = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
    output logic                     ram_read_en_o,
    input  logic                     ram_read_data_i,
    output logic [SAMPLE_BITS-1:0]   sample_data_o,
    output logic [2:0]               sample_channel_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic [CIRC_BUF_BITS-1:0] frame_idx_o,
    output logic [7:0]               dropped_frames_o
);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, PRESENT} state_t;

    localparam int AW = CIRC_BUF_BITS + 8;

    state_t                   state_q, state_d;
    logic [CIRC_BUF_BITS-1:0] idx_seen_q, idx_seen_d;
    logic [CIRC_BUF_BITS-1:0] frame_q, frame_d;
    logic [CIRC_BUF_BITS-1:0] pend_idx_q, pend_idx_d;
    logic                     pending_q, pending_d;
    logic [2:0]               ch_q, ch_d;
    logic [4:0]               b_q, b_d;
    logic [30:0]              shift_q, shift_d;
    logic                     rd_en_q, rd_en_d;
    logic [AW-1:0]            rd_addr_q, rd_addr_d;
    logic [SAMPLE_BITS-1:0]   data_q, data_d;
    logic [2:0]               chan_q, chan_d;
    logic                     valid_q, valid_d;
    logic [7:0]               drops_q, drops_d;

    logic                     change;
    logic                     hs;
    logic [31:0]              word;
    logic [CIRC_BUF_BITS-1:0] next_idx;

    // Next-state: change detect, overrun bookkeeping and the read FSM
    always_comb begin
        state_d    = state_q;
        idx_seen_d = last_good_frame_idx_i;
        frame_d    = frame_q;
        pend_idx_d = pend_idx_q;
        pending_d  = pending_q;
        ch_d       = ch_q;
        b_d        = b_q;
        shift_d    = shift_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        data_d     = data_q;
        chan_d     = chan_q;
        valid_d    = valid_q;
        drops_d    = drops_q;

        change   = last_good_frame_idx_i != idx_seen_q;
        hs       = valid_q && sample_ready_i;
        word     = {shift_q, ram_read_data_i};
        next_idx = change ? last_good_frame_idx_i : pend_idx_q;

        // Read data lags its strobe by one cycle, so the first READ
        // cycle of a slot has nothing to shift in yet.
        if ((state_q == READ && b_q != 5'd0) || state_q == CAPTURE) begin
            shift_d = word[30:0];
        end

        if (state_q != IDLE && change) begin
            pending_d  = 1'b1;
            pend_idx_d = last_good_frame_idx_i;
            if (pending_q && drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (change) begin
                    frame_d   = last_good_frame_idx_i;
                    ch_d      = 3'd0;
                    b_d       = 5'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {last_good_frame_idx_i, 8'd0};
                    state_d   = READ;
                end
            end
            READ: begin
                if (b_q == 5'd31) begin
                    state_d = CAPTURE;
                end else begin
                    b_d       = b_q + 5'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {frame_q, ch_q, b_q + 5'd1};
                end
            end
            CAPTURE: begin
                data_d  = word[31 -: SAMPLE_BITS];
                chan_d  = ch_q;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (ch_q != 3'd7) begin
                        ch_d      = ch_q + 3'd1;
                        b_d       = 5'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = {frame_q, ch_q + 3'd1, 5'd0};
                        state_d   = READ;
                    end else if (pending_q || change) begin
                        pending_d = 1'b0;
                        frame_d   = next_idx;
                        ch_d      = 3'd0;
                        b_d       = 5'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = {next_idx, 8'd0};
                        state_d   = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset parks the block and re-arms change detect
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_seen_q <= last_good_frame_idx_i;
            frame_q    <= '0;
            pend_idx_q <= '0;
            pending_q  <= 1'b0;
            ch_q       <= '0;
            b_q        <= '0;
            shift_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            data_q     <= '0;
            chan_q     <= '0;
            valid_q    <= 1'b0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_seen_q <= idx_seen_d;
            frame_q    <= frame_d;
            pend_idx_q <= pend_idx_d;
            pending_q  <= pending_d;
            ch_q       <= ch_d;
            b_q        <= b_d;
            shift_q    <= shift_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            valid_q    <= valid_d;
            drops_q    <= drops_d;
        end
    end

    assign ram_read_addr_o  = rd_addr_q;
    assign ram_read_en_o    = rd_en_q;
    assign sample_data_o    = data_q;
    assign sample_channel_o = chan_q;
    assign sample_valid_o   = valid_q;
    assign frame_idx_o      = frame_q;
    assign dropped_frames_o = drops_q;

endmodule

// File: doc/i2s_frame_unpacker.md
Name: i2s_frame_unpacker

Overview:
Downstream consumer of the I2S MSB receiver's bit-wide circular frame RAM. When the receiver publishes a new last-good frame index, this block reads that frame's 256 bits back through the RAM read port. It assembles them into eight 32-bit MSB-first slots and presents each slot's top 24 bits as a channel sample over a valid/ready stream. It feeds the ADAT transmit sample path.

Parameters:
CIRC_BUF_BITS, 3, log2 of frames in the circular buffer; must match the receiver.
SAMPLE_BITS, 24, bits per output sample, taken from slot bits [31:32-SAMPLE_BITS]; legal range 1..32.

Ports:
clk_i  in  1  block clock; also clocks the RAM read port.
rst_ni  in  1  synchronous reset, active low.
last_good_frame_idx_i  in  CIRC_BUF_BITS  newest complete frame index; already synchronised into the clk_i domain.
ram_read_addr_o  out  CIRC_BUF_BITS+8  read address {frame, bit[7:0]}.
ram_read_en_o  out  1  read strobe.
ram_read_data_i  in  1  read data, valid exactly 1 cycle after the strobe.
sample_data_o  out  SAMPLE_BITS  channel sample.
sample_channel_o  out  3  channel number 0..7.
sample_valid_o  out  1  sample valid.
sample_ready_i  in  1  consumer accepts.
frame_idx_o  out  CIRC_BUF_BITS  frame currently being unpacked.
dropped_frames_o  out  8  saturating count of frames skipped because of overrun.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; pending flag is cleared.
  - idx_seen loads last_good_frame_idx_i, so the index present at reset never triggers a frame.
- Reset asserted mid-operation: the operation aborts. All outputs are 0 on the cycle after the reset edge, and there is no resume after reset.
- Change detect: a change is last_good_frame_idx_i != idx_seen. On a change, idx_seen takes the new value.
- Frame selection in IDLE: on a change, latch frame_idx_o = new index, set ch = 0, and enter READ.
- Frame selection while not IDLE:
  - A change sets pending and stores pend_idx = new index.
  - If pending is already set, pend_idx is overwritten and dropped_frames_o increments, saturating at 255.
- FSM states: IDLE, READ, CAPTURE, PRESENT.
- READ:
  - Lasts 32 cycles. bit counter b runs 0..31.
  - ram_read_en_o = 1 and ram_read_addr_o = {frame_idx_o, ch*32 + b}; both are registered outputs.
  - ram_read_data_i is shifted into a 32-bit shift register, MSB first, one cycle after each strobe. Address ch*32 is the slot MSB.
  - After b = 31, go to CAPTURE.
- CAPTURE:
  - Lasts 1 cycle; ram_read_en_o = 0.
  - The final bit is shifted in.
  - Load sample_data_o = shift[31:32-SAMPLE_BITS] and sample_channel_o = ch.
  - Go to PRESENT with sample_valid_o = 1.
- PRESENT:
  - sample_data_o, sample_channel_o and sample_valid_o are held stable until sample_valid_o && sample_ready_i.
  - No RAM reads are issued in this state.
  - On handshake with ch < 7: sample_valid_o goes to 0, ch increments, and the FSM re-enters READ next cycle.
  - On handshake with ch == 7 and pending set: clear pending, set frame_idx_o = pend_idx, ch = 0, go to READ.
  - On handshake with ch == 7 and pending clear: go to IDLE.
- Latency (cycle 0 = first cycle the new index is on the input):
  - Strobes occur in cycles 1..32; CAPTURE is cycle 33; sample_valid_o first goes high in cycle 34.
  - With sample_ready_i tied high, a channel occupies 34 cycles and a frame 272 cycles.
- Simultaneous events:
  - A change in the same cycle as the ch==7 handshake is treated as pending: it is processed directly and is not counted as a drop.
  - If that change overwrites an existing pending index, the drop count increments and the newer index is used.
- Wrap-around:
  - Index 7 to 0 is an ordinary change.
  - The address high field wraps naturally with CIRC_BUF_BITS; no special case.
- sample_channel_o wraps 7 to 0 only through a new frame.

Test Plan:
1. Reset with idx_i = 5, hold 500 cycles -> ram_read_en_o never asserted, sample_valid_o = 0, dropped_frames_o = 0.
2. Preload frame 1, slot k = {k*24'h111111, 8'hA5}; change idx 5->1, ready tied high -> reads at 0x100..0x11F in cycles 1..32, first valid in cycle 34; samples 0x000000, 0x111111 .. 0x777777 on channels 0..7 in order; frame_idx_o = 1.
3. Backpressure: drop ready for 10 cycles while ch = 3 is presented -> data 0x333333 and channel 3 held stable, no strobes issued; ch4 reads start the cycle after the handshake.
4. Overrun: during frame 1 unpack, change to 2 then to 3 -> dropped_frames_o = 1; frame 3 is read (addresses 0x3xx) immediately after the ch7 handshake of frame 1; frame 2 is never read.
5. Wrap and simultaneous events: change 7->0 in the same cycle as the ch7 handshake of frame 7 -> frame 0 starts next cycle at address 0x000, no drop counted. Force 300 overwrites -> counter saturates at 255.
6. Reset mid-READ of ch2 -> all outputs 0 the next cycle; after release, no reads occur until the index changes again.
